digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder.sv | 174 +++++++++++++++++
 tb/tb_digit_serial_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder
// Brief    : WIDTH-bit add/subtract, DIGIT bits per clock, valid/ready I/O.
//            Optional zero output when DSA_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef DSA_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] acc_next;

  // Ripple chain of DIGIT full adders fed by the registered carry.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign dsum[i]    = a_q[i] ^ b_q[i] ^ chain[i];
    assign chain[i+1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
  end

  // Partial result: the upper WIDTH-DIGIT bits collected so far, newest digit on top.
  if (DIGIT == WIDTH) begin : g_acc_none
    assign acc_next = dsum;
  end else begin : g_acc
    logic [WIDTH-DIGIT-1:0] acc_q;
    assign acc_next = {dsum, acc_q};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_next[WIDTH-1:DIGIT];
      end
    end
  end

`ifdef DSA_ZERO_FLAG_EN
  logic zacc_q, zacc_d;
  logic zero_q, zero_d;
  logic last_digit;
  assign last_digit = (state_q == CALC) && (cnt_q == LAST);

  always_comb begin
    zacc_d = zacc_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      zacc_d = 1'b1;
    end else if (state_q == CALC) begin
      zacc_d = zacc_q & ~|dsum;
      if (last_digit) zero_d = zacc_q & ~|dsum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = x;
          b_d     = sub ? ~y : y;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          s_d     = acc_next;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_adder
// Brief    : Directed bench for digit_serial_adder at DIGIT = 1, 4 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;

  logic [2:0]        in_ready, out_valid, cout, ovf;
  logic [2:0][W-1:0] s;
`ifdef DSA_ZERO_FLAG_EN
  logic [2:0]        zero;
`endif

  int nvec  = 0;
  int nfail = 0;
  int exp_lat [3] = '{16, 4, 1};

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready), .s(s[0]), .cout(cout[0]), .ovf(ovf[0])
`ifdef DSA_ZERO_FLAG_EN
    , .zero(zero[0])
`endif
  );

  digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready), .s(s[1]), .cout(cout[1]), .ovf(ovf[1])
`ifdef DSA_ZERO_FLAG_EN
    , .zero(zero[1])
`endif
  );

  digit_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready), .s(s[2]), .cout(cout[2]), .ovf(ovf[2])
`ifdef DSA_ZERO_FLAG_EN
    , .zero(zero[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction through all three instances; expected values hand-computed.
  task automatic run(input logic [W-1:0] xa, input logic [W-1:0] ya,
                     input logic ci, input logic su,
                     input logic [W-1:0] es, input logic ec, input logic eo,
                     input logic ez);
    int lat [3];
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("in_ready_idle[%0d]", i), in_ready[i], 1);
    x = xa; y = ya; cin = ci; sub = su; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = '{-1, -1, -1};
    for (int k = 0; k <= 40; k++) begin
      for (int i = 0; i < 3; i++)
        if (lat[i] < 0 && out_valid[i]) lat[i] = k;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency[%0d] %h%s%h", i, xa, su ? "-" : "+", ya), lat[i], exp_lat[i]);
      chk($sformatf("s[%0d] %h%s%h", i, xa, su ? "-" : "+", ya), s[i], es);
      chk($sformatf("cout[%0d] %h%s%h", i, xa, su ? "-" : "+", ya), cout[i], ec);
      chk($sformatf("ovf[%0d] %h%s%h", i, xa, su ? "-" : "+", ya), ovf[i], eo);
`ifdef DSA_ZERO_FLAG_EN
      chk($sformatf("zero[%0d] %h%s%h", i, xa, su ? "-" : "+", ya), zero[i], ez);
`else
      if (ez) begin end
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("out_valid_drop[%0d]", i), out_valid[i], 0);
  endtask

  initial begin
    // Reset state
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
      chk($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
      chk($sformatf("rst_s[%0d]", i), s[i], 0);
      chk($sformatf("rst_cout[%0d]", i), cout[i], 0);
      chk($sformatf("rst_ovf[%0d]", i), ovf[i], 0);
`ifdef DSA_ZERO_FLAG_EN
      chk($sformatf("rst_zero[%0d]", i), zero[i], 0);
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   x        y        cin   sub   s        cout  ovf   zero
    run(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0);
    run(16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0, 1'b0);
    run(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run(16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure in DONE with a competing in_valid
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && out_valid != 3'b111; k++) @(negedge clk);
    chk("bp_all_done", out_valid, 3'b111);
    x = 16'hFFFF; y = 16'hFFFF; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_out_valid_c%0d", c), out_valid[1], 1);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready[1], 0);
      chk($sformatf("bp_s_c%0d", c), s[1], 16'h3333);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid[1], 0);
    chk("bp_release_in_ready", in_ready[1], 1);
    chk("bp_hold_s_idle", s[1], 16'h3333);
    @(negedge clk);
    chk("bp_no_accept_in_ready", in_ready[1], 1);

    // Asynchronous reset two cycles into CALC
    x = 16'h4321; y = 16'h1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_in_ready", in_ready[1], 0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_out_valid[%0d]", i), out_valid[i], 0);
      chk($sformatf("arst_s[%0d]", i), s[i], 0);
      chk($sformatf("arst_in_ready[%0d]", i), in_ready[i], 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
